if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, default 32'h00000000, word address loaded into the PC on reset.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: stall  input  1  hazard-unit request to hold the PC and the IF/ID register.
REQ-005 Port: flush  input  1  squash the IF/ID register to a bubble on this edge.
REQ-006 Port: redirect_en  input  1  branch/jump taken; load redirect_pc into the PC.
REQ-007 Port: redirect_pc  input  32  word-address target for a branch or jump.
REQ-008 Port: rom_addr  output  6  word address to the instruction ROM, equal to pc[5:0], combinational.
REQ-009 Port: rom_inst  input  32  instruction returned combinationally by the ROM for rom_addr.
REQ-010 Port: pc  output  32  current fetch PC (word address), registered.
REQ-011 Port: if_id_pc  output  32  PC of the instruction held in IF/ID.
REQ-012 Port: if_id_inst  output  32  instruction held in IF/ID.
REQ-013 Port: if_id_valid  output  1  IF/ID holds a real instruction, not a bubble.

Function
REQ-014 Next-PC priority SHALL be: redirect_en -> redirect_pc; else stall -> hold pc; else pc+1.
REQ-015 The PC SHALL be word-addressed, and pc+1 SHALL wrap modulo 2^32 (32'hFFFFFFFF+1 = 0).
REQ-016 rom_addr SHALL be pc[5:0] with no register stage, so pc 32'h0000003F followed by pc 32'h00000040 gives rom_addr 6'h00.
REQ-017 IF/ID update priority SHALL be: redirect_en or flush -> bubble; else stall -> hold; else load {pc, rom_inst, valid=1}.
REQ-018 A bubble SHALL set if_id_pc=0, if_id_inst=32'h00000000 (NOP) and if_id_valid=0.
REQ-019 Fetch latency SHALL be 1 cycle: an instruction addressed in cycle N appears on the if_id_* outputs after edge N+1.
REQ-020 With stall, flush and redirect_en all low, throughput SHALL be one instruction per cycle.
REQ-021 If stall and redirect_en are both asserted, the redirect SHALL win: the PC loads the target and IF/ID becomes a bubble.
REQ-022 If stall and flush are both asserted without redirect_en, the PC SHALL hold and IF/ID SHALL become a bubble.
REQ-023 If stall is held for several cycles, the PC and IF/ID SHALL stay unchanged for the whole period.
REQ-024 redirect_pc SHALL be stored in full 32 bits, and only bits [5:0] SHALL drive rom_addr.

Reset
REQ-025 Asserting resetn low SHALL immediately, without waiting for a clock edge, set pc=RESET_PC, if_id_pc=0, if_id_inst=0 and if_id_valid=0.
REQ-026 After resetn deasserts, the first edge SHALL load IF/ID with {RESET_PC, rom[RESET_PC[5:0]], 1} and advance the PC to RESET_PC+1.
REQ-027 A reset asserted mid-stall or mid-redirect SHALL override every other input.

Configuration
REQ-028 When IF_PERF_CNT_EN is defined, the block SHALL add outputs fetch_cnt[15:0] and stall_cnt[15:0], both reset to 0.
REQ-029 With IF_PERF_CNT_EN defined, fetch_cnt SHALL increment on each edge that loads a valid instruction into IF/ID.
REQ-030 With IF_PERF_CNT_EN defined, stall_cnt SHALL increment on each edge where stall=1 and redirect_en=0.
REQ-031 With IF_PERF_CNT_EN defined, both counters SHALL saturate at 16'hFFFF.
REQ-032 When IF_PERF_CNT_EN is undefined, the counter ports and counter logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 Reset then free-run, ROM rom[1]=32'h00101464 -> after edge 2: if_id_pc=1, if_id_inst=32'h00101464, if_id_valid=1, pc=2.
REQ-034 Stall asserted for 3 cycles at pc=5 -> pc stays 5 and the if_id_* outputs hold their values for 3 edges; fetch resumes at pc 5 and pc 6.
REQ-035 redirect_en=1, redirect_pc=32'h0000000A while pc=4 -> next edge gives pc=10 and if_id_valid=0; the edge after loads IF/ID with pc 10 and rom[6'h0A]=32'h04100841.
REQ-036 stall=1 together with redirect_en=1 and redirect_pc=1 -> pc=1 and IF/ID is a bubble (the redirect wins).
REQ-037 Free-run through pc=32'h0000003F -> the next rom_addr is 6'h00 and pc=32'h00000040.
REQ-038 resetn pulsed low between clock edges during a stall -> the outputs take their reset values immediately; with IF_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction fetch stage of a simple in-order pipeline.
//
// Keeps the word-addressed fetch PC, drives the instruction ROM address, and
// registers the fetched instruction into the IF/ID pipeline register.
//
// Parameters
//   RESET_PC     word address loaded into the PC on reset
//
// Ports
//   clk          single clock, rising-edge
//   resetn       asynchronous active-low reset
//   stall        hold the PC and the IF/ID register
//   flush        squash IF/ID to a bubble on this edge
//   redirect_en  branch/jump taken: load redirect_pc into the PC
//   redirect_pc  32-bit word-address target
//   rom_addr     pc[5:0] to the instruction ROM (combinational)
//   rom_inst     instruction returned combinationally by the ROM
//   pc           current fetch PC (registered)
//   if_id_pc     PC of the instruction held in IF/ID (0 for a bubble)
//   if_id_inst   instruction held in IF/ID (NOP for a bubble)
//   if_id_valid  IF/ID holds a real instruction
//
// Optional feature (macro IF_PERF_CNT_EN)
//   fetch_cnt    saturating count of edges that load a valid instruction
//   stall_cnt    saturating count of edges with stall=1 and redirect_en=0
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [5:0]  rom_addr,
  input  logic [31:0] rom_inst,
  output logic [31:0] pc,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] fetch_cnt,
  output logic [15:0] stall_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic [31:0] next_pc;
  logic        squash;     // redirect or flush turns IF/ID into a bubble
  logic        load_ifid;  // a real instruction enters IF/ID on this edge

  assign squash    = redirect_en | flush;
  assign load_ifid = ~squash & ~stall;

  // The ROM is asynchronous, so the address is the raw PC with no register.
  assign rom_addr = pc[5:0];

  // Redirect beats stall; otherwise sequential fetch, wrapping modulo 2^32.
  always_comb begin
    // NOTE: assign a default before the branches so no path leaves next_pc
    // unassigned, which would infer a latch.
    next_pc = pc + 32'd1;
    if (redirect_en) begin
      next_pc = redirect_pc;
    end else if (stall) begin
      next_pc = pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  // IF/ID register: bubble on squash, hold on stall, otherwise capture the
  // instruction addressed by the current PC (one-cycle fetch latency).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      if_id_pc    <= 32'd0;
      if_id_inst  <= NOP;
      if_id_valid <= 1'b0;
    end else if (squash) begin
      if_id_pc    <= 32'd0;
      if_id_inst  <= NOP;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_pc    <= pc;
      if_id_inst  <= rom_inst;
      if_id_valid <= 1'b1;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic stall_evt;
  assign stall_evt = stall & ~redirect_en;

  // Both counters stop at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_cnt <= 16'd0;
      stall_cnt <= 16'd0;
    end else begin
      if (load_ifid && fetch_cnt != 16'hFFFF) begin
        fetch_cnt <= fetch_cnt + 16'd1;
      end
      if (stall_evt && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A behavioural model of the fetch stage runs alongside the DUT and is
// compared on every falling edge; directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall, flush, redirect_en;
  logic [31:0] redirect_pc;
  logic [5:0]  rom_addr;
  logic [31:0] rom_inst;
  logic [31:0] pc, if_id_pc, if_id_inst;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt;
`endif

  logic [31:0] rom [64];
  assign rom_inst = rom[rom_addr];

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .stall       (stall),
    .flush       (flush),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .rom_addr    (rom_addr),
    .rom_inst    (rom_inst),
    .pc          (pc),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc, m_ifpc, m_inst;
  logic        m_valid;
  int unsigned m_fetch, m_stall;  // unbounded counts, clamped at compare

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_pc = RESET_PC; m_ifpc = 0; m_inst = 0; m_valid = 0;
      m_fetch = 0; m_stall = 0;
    end else begin
      logic [31:0] fetched_pc;
      fetched_pc = m_pc;
      if (redirect_en)  m_pc = redirect_pc;
      else if (!stall)  m_pc = m_pc + 1;
      if (redirect_en || flush) begin
        m_ifpc = 0; m_inst = 0; m_valid = 0;
      end else if (!stall) begin
        m_ifpc = fetched_pc; m_inst = rom[fetched_pc % 64]; m_valid = 1;
        m_fetch++;
      end
      if (stall && !redirect_en) m_stall++;
    end
  end

  bit cmp_en = 0;
  always @(negedge clk) begin
    if (cmp_en) begin
      check("pc", pc, m_pc);
      check("rom_addr", {26'd0, rom_addr}, m_pc % 64);
      check("if_id_pc", if_id_pc, m_ifpc);
      check("if_id_inst", if_id_inst, m_inst);
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
`ifdef IF_PERF_CNT_EN
      check("fetch_cnt", {16'd0, fetch_cnt}, (m_fetch > 65535) ? 65535 : m_fetch);
      check("stall_cnt", {16'd0, stall_cnt}, (m_stall > 65535) ? 65535 : m_stall);
`endif
    end
  end

  // one rising edge, then settle just after it
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] epc,
                            input logic [31:0] einst, input logic evalid);
    check({tag, ".if_id_pc"}, if_id_pc, epc);
    check({tag, ".if_id_inst"}, if_id_inst, einst);
    check({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, evalid});
  endtask

  logic [31:0] hold_inst;

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    rom[1]  = 32'h0010_1464;
    rom[10] = 32'h0410_0841;
    resetn = 0; stall = 0; flush = 0; redirect_en = 0; redirect_pc = 0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst.pc", pc, RESET_PC);
    check_ifid("rst", 32'd0, 32'd0, 1'b0);
    resetn = 1;
    cmp_en = 1;

    // free run: after edge 2 IF/ID holds pc 1
    cyc();
    check_ifid("edge1", 32'd0, rom[0], 1'b1);
    cyc();
    check_ifid("edge2", 32'd1, 32'h0010_1464, 1'b1);
    check("edge2.pc", pc, 32'd2);

    // stall three cycles at pc=5
    repeat (3) cyc();
    check("pre_stall.pc", pc, 32'd5);
    hold_inst = if_id_inst;
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall.pc", pc, 32'd5);
      check_ifid("stall", 32'd4, hold_inst, 1'b1);
    end
    stall = 0;
    cyc();
    check_ifid("resume5", 32'd5, rom[5], 1'b1);
    check("resume5.pc", pc, 32'd6);
    cyc();
    check_ifid("resume6", 32'd6, rom[6], 1'b1);

    // redirect to 10 while pc=4
    redirect_en = 1; redirect_pc = 32'd4;
    cyc();
    check("to4.pc", pc, 32'd4);
    redirect_pc = 32'h0000_000A;
    cyc();
    check("to10.pc", pc, 32'd10);
    check("to10.valid", {31'd0, if_id_valid}, 32'd0);
    redirect_en = 0;
    cyc();
    check_ifid("after10", 32'd10, 32'h0410_0841, 1'b1);
    check("after10.pc", pc, 32'd11);

    // stall + redirect: redirect wins
    stall = 1; redirect_en = 1; redirect_pc = 32'd1;
    cyc();
    check("stall_redir.pc", pc, 32'd1);
    check_ifid("stall_redir", 32'd0, 32'd0, 1'b0);

    // rom_addr wraps at pc 0x40
    stall = 0; redirect_pc = 32'h0000_003F;
    cyc();
    check("pc3f.rom_addr", {26'd0, rom_addr}, 32'h3F);
    redirect_en = 0;
    cyc();
    check("pc40.pc", pc, 32'h0000_0040);
    check("pc40.rom_addr", {26'd0, rom_addr}, 32'h00);

    // PC wraps modulo 2^32; full 32-bit target kept
    redirect_en = 1; redirect_pc = 32'hFFFF_FFFF;
    cyc();
    check("pcmax.pc", pc, 32'hFFFF_FFFF);
    redirect_en = 0;
    cyc();
    check("wrap.pc", pc, 32'd0);
    check_ifid("wrap", 32'hFFFF_FFFF, rom[63], 1'b1);

    // stall + flush: PC holds, IF/ID bubbles
    stall = 1; flush = 1;
    cyc();
    check("stall_flush.pc", pc, 32'd0);
    check_ifid("stall_flush", 32'd0, 32'd0, 1'b0);
    stall = 0; flush = 0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      stall       = ($urandom_range(0, 3) == 0);
      flush       = ($urandom_range(0, 7) == 0);
      redirect_en = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 80);
      cyc();
    end

    // reset pulsed between edges during a stall
    stall = 1; flush = 0; redirect_en = 0;
    repeat (2) cyc();
    #2;
    resetn = 0;
    #1;
    check("midrst.pc", pc, RESET_PC);
    check_ifid("midrst", 32'd0, 32'd0, 1'b0);
`ifdef IF_PERF_CNT_EN
    check("midrst.fetch_cnt", {16'd0, fetch_cnt}, 32'd0);
    check("midrst.stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    @(negedge clk);
    resetn = 1;
    stall = 0;
    repeat (4) cyc();
    check("postrst.pc", pc, RESET_PC + 32'd4);

`ifdef IF_PERF_CNT_EN
    // drive stall_cnt into saturation
    stall = 1;
    repeat (65540) cyc();
    check("sat.stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    stall = 0;
`endif

    cmp_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
